// File: rtl/core_pkg.sv
// Shared core definitions for the memory pipeline.
// Contents: RV32I load/store funct3 encodings, the load/store opcodes, the
// operand-tag pending convention, the default start of the IO address window,
// the load/store queue FSM state type and two access-decoding helpers.
package core_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Operand tags are {pending, rob_pos}: a set MSB means the value is still
    // being produced by the ROB slot in the low bits.
    localparam logic TAG_PENDING = 1'b1;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } lsq_state_e;

    // Access size in bytes encoded in funct3[1:0].
    function automatic logic [2:0] access_len(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Memory returns zero-extended raw data; apply the load's own extension.
    function automatic logic [31:0] load_extend(input logic [2:0] funct3,
                                                input logic [31:0] raw);
        case (funct3)
            F3_LB:   return {{24{raw[7]}}, raw[7:0]};
            F3_LH:   return {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  return {24'b0, raw[7:0]};
            F3_LHU:  return {16'b0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/load_store_queue_if.sv
// Bus bundle around the load/store queue: dispatch issue port, result
// broadcast snoop, ROB commit/rollback, memory-controller request and the
// load-result output.
// Modports: master = surrounding core/testbench, slave = the queue.
//
// Handshakes: dispatch may pulse issue in any cycle where it sampled full=0
// (full is a registered look-ahead of next-cycle occupancy). A memory request
// is mc_en held high with stable mc_addr/mc_len/mc_wr/mc_w_data until the
// controller answers with a single-cycle mc_done; mc_en drops the cycle after.
// result is a single-cycle pulse with no back-pressure.
interface load_store_queue_if #(
    parameter int ROB_POS_W = 4,
    parameter int NUM_CDB   = 2
);
    logic                          rdy;
    logic                          rollback;
    logic                          full;
    logic                          issue;
    logic [ROB_POS_W-1:0]          issue_rob_pos;
    logic                          issue_is_store;
    logic [2:0]                    issue_funct3;
    logic [31:0]                   issue_rs1_val;
    logic [31:0]                   issue_rs2_val;
    logic [ROB_POS_W:0]            issue_rs1_tag;
    logic [ROB_POS_W:0]            issue_rs2_tag;
    logic [31:0]                   issue_imm;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB*ROB_POS_W-1:0]  cdb_rob_pos;
    logic [NUM_CDB*32-1:0]         cdb_val;
    logic                          commit;
    logic [ROB_POS_W-1:0]          commit_rob_pos;
    logic                          mc_en;
    logic                          mc_wr;
    logic [31:0]                   mc_addr;
    logic [2:0]                    mc_len;
    logic [31:0]                   mc_w_data;
    logic                          mc_done;
    logic [31:0]                   mc_r_data;
    logic                          result;
    logic [ROB_POS_W-1:0]          result_rob_pos;
    logic [31:0]                   result_val;

    modport master (
        output rdy, rollback, issue, issue_rob_pos, issue_is_store, issue_funct3,
               issue_rs1_val, issue_rs2_val, issue_rs1_tag, issue_rs2_tag, issue_imm,
               cdb_valid, cdb_rob_pos, cdb_val, commit, commit_rob_pos,
               mc_done, mc_r_data,
        input  full, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
               result, result_rob_pos, result_val
    );

    modport slave (
        input  rdy, rollback, issue, issue_rob_pos, issue_is_store, issue_funct3,
               issue_rs1_val, issue_rs2_val, issue_rs1_tag, issue_rs2_tag, issue_imm,
               cdb_valid, cdb_rob_pos, cdb_val, commit, commit_rob_pos,
               mc_done, mc_r_data,
        output full, mc_en, mc_wr, mc_addr, mc_len, mc_w_data,
               result, result_rob_pos, result_val
    );
endinterface

// File: rtl/lsq_wakeup.sv
// Combinational operand wakeup: compares one operand tag against every
// result-broadcast channel.
// Ports: tag/val_in = stored operand; cdb_* = packed broadcast channels;
// ready = operand available now; val_out = broadcast value on a hit, else val_in.
module lsq_wakeup #(
    parameter int ROB_POS_W = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic [ROB_POS_W:0]           tag,
    input  logic [31:0]                  val_in,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*ROB_POS_W-1:0] cdb_rob_pos,
    input  logic [NUM_CDB*32-1:0]        cdb_val,
    output logic                         ready,
    output logic [31:0]                  val_out
);
    always_comb begin
        ready   = !tag[ROB_POS_W];
        val_out = val_in;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (tag[ROB_POS_W] && cdb_valid[k] &&
                tag[ROB_POS_W-1:0] == cdb_rob_pos[k*ROB_POS_W +: ROB_POS_W]) begin
                ready   = 1'b1;
                val_out = cdb_val[k*32 +: 32];
            end
        end
    end
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch, the ROB and the memory
// controller. Entries wait for operands (snooping the broadcast channels),
// then the head is sent to memory: stores and IO loads only once committed,
// other loads speculatively. Rollback trims uncommitted entries; a
// speculative access already in flight is drained and its result dropped.
// Ports: clk, rst (sync, active-high); bus = load_store_queue_if.slave;
// state_dbg = current FSM state.
module load_store_queue
    import core_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          ROB_POS_W = 4,
    parameter int          NUM_CDB   = 2,
    parameter logic [31:0] IO_BASE   = DEFAULT_IO_BASE
) (
    input  logic               clk,
    input  logic               rst,
    load_store_queue_if.slave  bus,
    output lsq_state_e         state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ROB_POS_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ROB_POS_W-1:0] e_rob_pos   [DEPTH];
    logic                 e_is_store  [DEPTH];
    logic [2:0]           e_funct3    [DEPTH];
    logic [31:0]          e_rs1_val   [DEPTH];
    logic [31:0]          e_rs2_val   [DEPTH];
    logic [TAG_W-1:0]     e_rs1_tag   [DEPTH];
    logic [TAG_W-1:0]     e_rs2_tag   [DEPTH];
    logic [31:0]          e_imm       [DEPTH];
    logic                 e_committed [DEPTH];

    logic [PTR_W-1:0] head, tail, head_n, tail_n;
    logic [CNT_W-1:0] count, count_n, n_committed;
    lsq_state_e       state;

    logic [DEPTH-1:0] busy, commit_hit, cmt_now, rs1_wk_rdy, rs2_wk_rdy;
    logic [31:0]      rs1_wk_val [DEPTH];
    logic [31:0]      rs2_wk_val [DEPTH];
    logic             iss_rs1_rdy, iss_rs2_rdy;
    logic [31:0]      iss_rs1_val, iss_rs2_val;

    assign state_dbg = state;

    lsq_wakeup #(.ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_wk_iss_rs1 (
        .tag(bus.issue_rs1_tag), .val_in(bus.issue_rs1_val), .cdb_valid(bus.cdb_valid),
        .cdb_rob_pos(bus.cdb_rob_pos), .cdb_val(bus.cdb_val),
        .ready(iss_rs1_rdy), .val_out(iss_rs1_val));
    lsq_wakeup #(.ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_wk_iss_rs2 (
        .tag(bus.issue_rs2_tag), .val_in(bus.issue_rs2_val), .cdb_valid(bus.cdb_valid),
        .cdb_rob_pos(bus.cdb_rob_pos), .cdb_val(bus.cdb_val),
        .ready(iss_rs2_rdy), .val_out(iss_rs2_val));

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        // Entry i is occupied when its distance from head is below count.
        assign busy[i]       = {1'b0, PTR_W'(i) - head} < count;
        assign commit_hit[i] = bus.rdy && bus.commit && e_rob_pos[i] == bus.commit_rob_pos;
        // Committed including a commit arriving this cycle.
        assign cmt_now[i]    = busy[i] && (e_committed[i] || commit_hit[i]);

        lsq_wakeup #(.ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_wk_rs1 (
            .tag(e_rs1_tag[i]), .val_in(e_rs1_val[i]), .cdb_valid(bus.cdb_valid),
            .cdb_rob_pos(bus.cdb_rob_pos), .cdb_val(bus.cdb_val),
            .ready(rs1_wk_rdy[i]), .val_out(rs1_wk_val[i]));
        lsq_wakeup #(.ROB_POS_W(ROB_POS_W), .NUM_CDB(NUM_CDB)) u_wk_rs2 (
            .tag(e_rs2_tag[i]), .val_in(e_rs2_val[i]), .cdb_valid(bus.cdb_valid),
            .cdb_rob_pos(bus.cdb_rob_pos), .cdb_val(bus.cdb_val),
            .ready(rs2_wk_rdy[i]), .val_out(rs2_wk_val[i]));
    end

    always_comb begin
        n_committed = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cmt_now[i]) n_committed = n_committed + CNT_W'(1);
        end
    end

    logic [31:0] head_addr;
    logic        head_is_io, head_cmt, head_elig, pop, issue_ok, head_keep;

    assign head_addr  = e_rs1_val[head] + e_imm[head];
    assign head_is_io = head_addr >= IO_BASE;
    assign head_cmt   = cmt_now[head];
    assign head_elig  = (count != '0) && !e_rs1_tag[head][TAG_W-1] && !e_rs2_tag[head][TAG_W-1] &&
                        (head_cmt || (!e_is_store[head] && !head_is_io && !bus.rollback));
    assign pop        = bus.rdy && (state != ST_IDLE) && bus.mc_done;
    assign issue_ok   = bus.rdy && bus.issue && !bus.rollback && (count != DEPTH_CNT);
    // An uncommitted access still in flight must stay resident until its
    // mc_done arrives, so rollback keeps it in front of the committed entries.
    assign head_keep  = (state != ST_IDLE) && !head_cmt && !pop;

    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count;
        if (bus.rollback) begin
            head_n  = pop ? head + PTR_W'(1) : head;
            count_n = n_committed + CNT_W'(head_keep) - CNT_W'(pop && head_cmt);
            tail_n  = head_n + count_n[PTR_W-1:0];
        end else begin
            if (pop)      head_n = head + PTR_W'(1);
            if (issue_ok) tail_n = tail + PTR_W'(1);
            count_n = count + CNT_W'(issue_ok) - CNT_W'(pop);
        end
    end

    // Entry storage: issue write, operand wakeup and commit marking.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_rob_pos[i]   <= '0;
                e_is_store[i]  <= 1'b0;
                e_funct3[i]    <= '0;
                e_rs1_val[i]   <= '0;
                e_rs2_val[i]   <= '0;
                e_rs1_tag[i]   <= '0;
                e_rs2_tag[i]   <= '0;
                e_imm[i]       <= '0;
                e_committed[i] <= 1'b0;
            end
        end else if (bus.rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_ok && tail == PTR_W'(i)) begin
                    e_rob_pos[i]   <= bus.issue_rob_pos;
                    e_is_store[i]  <= bus.issue_is_store;
                    e_funct3[i]    <= bus.issue_funct3;
                    e_rs1_val[i]   <= iss_rs1_val;
                    e_rs2_val[i]   <= iss_rs2_val;
                    e_rs1_tag[i]   <= iss_rs1_rdy ? '0 : bus.issue_rs1_tag;
                    e_rs2_tag[i]   <= iss_rs2_rdy ? '0 : bus.issue_rs2_tag;
                    e_imm[i]       <= bus.issue_imm;
                    e_committed[i] <= 1'b0;
                end else begin
                    if (rs1_wk_rdy[i]) begin
                        e_rs1_tag[i] <= '0;
                        e_rs1_val[i] <= rs1_wk_val[i];
                    end
                    if (rs2_wk_rdy[i]) begin
                        e_rs2_tag[i] <= '0;
                        e_rs2_val[i] <= rs2_wk_val[i];
                    end
                    if (commit_hit[i] && busy[i]) e_committed[i] <= 1'b1;
                end
            end
        end
    end

    // Pointers, look-ahead full flag and the memory-request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            state              <= ST_IDLE;
            bus.full           <= 1'b0;
            bus.mc_en          <= 1'b0;
            bus.mc_wr          <= 1'b0;
            bus.mc_addr        <= '0;
            bus.mc_len         <= '0;
            bus.mc_w_data      <= '0;
            bus.result         <= 1'b0;
            bus.result_rob_pos <= '0;
            bus.result_val     <= '0;
        end else begin
            if (bus.rdy && bus.issue && !bus.rollback)
                assert (count != DEPTH_CNT)
                    else $warning("load_store_queue: issue while full was dropped");
            head       <= head_n;
            tail       <= tail_n;
            count      <= count_n;
            bus.full   <= (count_n == DEPTH_CNT);
            bus.result <= 1'b0;
            if (bus.rdy) begin
                case (state)
                    ST_IDLE: begin
                        if (head_elig) begin
                            bus.mc_en   <= 1'b1;
                            bus.mc_wr   <= e_is_store[head];
                            bus.mc_addr <= head_addr;
                            bus.mc_len  <= access_len(e_funct3[head]);
                            if (e_is_store[head]) bus.mc_w_data <= e_rs2_val[head];
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.mc_done) begin
                            bus.mc_en <= 1'b0;
                            bus.mc_wr <= 1'b0;
                            state     <= ST_IDLE;
                            // A rollback in the completion cycle only discards
                            // the result of a speculative load.
                            if (!e_is_store[head] && (!bus.rollback || head_cmt)) begin
                                bus.result         <= 1'b1;
                                bus.result_rob_pos <= e_rob_pos[head];
                                bus.result_val     <= load_extend(e_funct3[head], bus.mc_r_data);
                            end
                        end else if (bus.rollback && !head_cmt) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (bus.mc_done) begin
                            bus.mc_en <= 1'b0;
                            bus.mc_wr <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (bus.rollback && state == ST_WAIT && !head_cmt) begin
                state <= ST_DRAIN;
            end
        end
    end
endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;
    import core_pkg::*;

    logic       clk;
    logic       rst;
    lsq_state_e state_dbg;
    int         n_cmp = 0;
    int         n_mis = 0;

    load_store_queue_if #(.ROB_POS_W(4), .NUM_CDB(2)) bus ();

    load_store_queue #(.DEPTH(4), .ROB_POS_W(4), .NUM_CDB(2), .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_dbg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue_op(input logic [3:0] rob, input logic st, input logic [2:0] f3,
                            input logic [31:0] rs1v, input logic [4:0] rs1t,
                            input logic [31:0] rs2v, input logic [4:0] rs2t,
                            input logic [31:0] imm);
        bus.issue = 1'b1; bus.issue_rob_pos = rob; bus.issue_is_store = st;
        bus.issue_funct3 = f3; bus.issue_rs1_val = rs1v; bus.issue_rs1_tag = rs1t;
        bus.issue_rs2_val = rs2v; bus.issue_rs2_tag = rs2t; bus.issue_imm = imm;
        tick();
        bus.issue = 1'b0;
    endtask

    task automatic commit_op(input logic [3:0] rob);
        bus.commit = 1'b1; bus.commit_rob_pos = rob;
        tick();
        bus.commit = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address, answers with one mc_done.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] rdata);
        int n = 0;
        while (bus.mc_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, bus.mc_en}, 32'd1);
        if (bus.mc_en === 1'b1) begin
            check({tag, "_addr"}, bus.mc_addr, exp_addr);
            bus.mc_done = 1'b1; bus.mc_r_data = rdata;
            tick();
            bus.mc_done = 1'b0; bus.mc_r_data = '0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1; bus.rollback = 1'b0; bus.issue = 1'b0; bus.issue_rob_pos = '0;
        bus.issue_is_store = 1'b0; bus.issue_funct3 = '0; bus.issue_rs1_val = '0;
        bus.issue_rs2_val = '0; bus.issue_rs1_tag = '0; bus.issue_rs2_tag = '0;
        bus.issue_imm = '0; bus.cdb_valid = '0; bus.cdb_rob_pos = '0; bus.cdb_val = '0;
        bus.commit = 1'b0; bus.commit_rob_pos = '0; bus.mc_done = 1'b0; bus.mc_r_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_full", {31'b0, bus.full}, 32'd0);
        check("rst_mc_en", {31'b0, bus.mc_en}, 32'd0);
        check("rst_mc_addr", bus.mc_addr, 32'd0);
        check("rst_result", {31'b0, bus.result}, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // LW minimum latency and data path
        issue_op(4'd1, 1'b0, F3_LW, 32'h100, 5'd0, 32'd0, 5'd0, 32'd4);
        check("lw_no_req_yet", {31'b0, bus.mc_en}, 32'd0);
        tick();
        check("lw_req", {31'b0, bus.mc_en}, 32'd1);
        check("lw_addr", bus.mc_addr, 32'h104);
        check("lw_len", {29'b0, bus.mc_len}, 32'd4);
        check("lw_wr", {31'b0, bus.mc_wr}, 32'd0);
        tick();
        check("lw_hold", {31'b0, bus.mc_en}, 32'd1);
        bus.mc_done = 1'b1; bus.mc_r_data = 32'hDEAD_BEEF;
        tick();
        bus.mc_done = 1'b0;
        check("lw_result", {31'b0, bus.result}, 32'd1);
        check("lw_val", bus.result_val, 32'hDEAD_BEEF);
        check("lw_rob", {28'b0, bus.result_rob_pos}, 32'd1);
        check("lw_en_drop", {31'b0, bus.mc_en}, 32'd0);
        tick();
        check("lw_pulse_end", {31'b0, bus.result}, 32'd0);

        // Sign/zero extension
        issue_op(4'd2, 1'b0, F3_LB, 32'h100, 5'd0, 32'd0, 5'd0, 32'd0);
        serve("lb", 32'h100, 32'h80);
        check("lb_val", bus.result_val, 32'hFFFF_FF80);
        issue_op(4'd3, 1'b0, F3_LBU, 32'h100, 5'd0, 32'd0, 5'd0, 32'd0);
        serve("lbu", 32'h100, 32'h80);
        check("lbu_val", bus.result_val, 32'h0000_0080);
        issue_op(4'd4, 1'b0, F3_LH, 32'h102, 5'd0, 32'd0, 5'd0, 32'd0);
        serve("lh", 32'h102, 32'h8001);
        check("lh_val", bus.result_val, 32'hFFFF_8001);
        check("lh_len", {29'b0, bus.mc_len}, 32'd2);
        issue_op(4'd5, 1'b0, F3_LHU, 32'h102, 5'd0, 32'd0, 5'd0, 32'd0);
        serve("lhu", 32'h102, 32'h8001);
        check("lhu_val", bus.result_val, 32'h0000_8001);

        // Store waits for commit
        issue_op(4'd6, 1'b1, F3_SW, 32'h200, 5'd0, 32'hCAFE_F00D, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sw_wait_commit", {31'b0, bus.mc_en}, 32'd0);
        end
        commit_op(4'd6);
        check("sw_req", {31'b0, bus.mc_en}, 32'd1);
        check("sw_wr", {31'b0, bus.mc_wr}, 32'd1);
        check("sw_data", bus.mc_w_data, 32'hCAFE_F00D);
        serve("sw", 32'h200, 32'd0);
        check("sw_no_result", {31'b0, bus.result}, 32'd0);

        // IO load waits for commit, then exactly one request
        issue_op(4'd7, 1'b0, F3_LW, 32'h0003_0000, 5'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("io_wait_commit", {31'b0, bus.mc_en}, 32'd0);
        end
        commit_op(4'd7);
        serve("io", 32'h0003_0000, 32'h1234_5678);
        check("io_val", bus.result_val, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("io_single_req", {31'b0, bus.mc_en}, 32'd0);
        end

        // Last non-IO address goes out speculatively
        issue_op(4'd8, 1'b0, F3_LW, 32'h0002_FFF0, 5'd0, 32'd0, 5'd0, 32'hC);
        tick();
        check("below_io_req", {31'b0, bus.mc_en}, 32'd1);
        serve("below_io", 32'h0002_FFFC, 32'h55);

        // Same-cycle wakeup on channel 1 at issue
        bus.cdb_valid = 2'b10; bus.cdb_rob_pos = {4'd9, 4'd3}; bus.cdb_val = {32'h400, 32'h999};
        issue_op(4'd10, 1'b0, F3_LW, 32'h0, {1'b1, 4'd9}, 32'd0, 5'd0, 32'h8);
        bus.cdb_valid = '0;
        tick();
        check("iss_wake_req", {31'b0, bus.mc_en}, 32'd1);
        serve("iss_wake", 32'h408, 32'h1);

        // Resident entry wakes up on channel 0
        issue_op(4'd11, 1'b0, F3_LW, 32'h0, {1'b1, 4'd12}, 32'd0, 5'd0, 32'h0);
        tick();
        check("res_pending", {31'b0, bus.mc_en}, 32'd0);
        bus.cdb_valid = 2'b01; bus.cdb_rob_pos = {4'd0, 4'd12}; bus.cdb_val = {32'h0, 32'h500};
        tick();
        bus.cdb_valid = '0;
        tick();
        check("res_wake_req", {31'b0, bus.mc_en}, 32'd1);
        serve("res_wake", 32'h500, 32'h2);

        // Rollback during a speculative load: drain, keep the committed store
        issue_op(4'd12, 1'b0, F3_LW, 32'h300, 5'd0, 32'd0, 5'd0, 32'd0);
        issue_op(4'd13, 1'b1, F3_SW, 32'h400, 5'd0, 32'hA5A5_A5A5, 5'd0, 32'd0);
        check("rb_load_req", {31'b0, bus.mc_en}, 32'd1);
        check("rb_load_addr", bus.mc_addr, 32'h300);
        issue_op(4'd14, 1'b0, F3_LW, 32'h500, 5'd0, 32'd0, 5'd0, 32'd0);
        commit_op(4'd13);
        bus.rollback = 1'b1;
        issue_op(4'd15, 1'b0, F3_LW, 32'h600, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.rollback = 1'b0;
        check("rb_drain", 32'(state_dbg), 32'(ST_DRAIN));
        check("rb_drain_en", {31'b0, bus.mc_en}, 32'd1);
        bus.mc_done = 1'b1; bus.mc_r_data = 32'h77;
        tick();
        bus.mc_done = 1'b0;
        check("rb_no_result", {31'b0, bus.result}, 32'd0);
        check("rb_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick();
        check("rb_store_req", {31'b0, bus.mc_en}, 32'd1);
        check("rb_store_wr", {31'b0, bus.mc_wr}, 32'd1);
        check("rb_store_data", bus.mc_w_data, 32'hA5A5_A5A5);
        serve("rb_store", 32'h400, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rb_dropped", {31'b0, bus.mc_en}, 32'd0);
        end

        // Full flag with DEPTH=4, fifth issue ignored
        for (int i = 1; i <= 4; i++) begin
            issue_op(4'(i), 1'b1, F3_SW, 32'h1000 + 32'(i) * 4, 5'd0, 32'(i), 5'd0, 32'd0);
            check("full_fill", {31'b0, bus.full}, (i == 4) ? 32'd1 : 32'd0);
        end
        issue_op(4'd5, 1'b1, F3_SW, 32'h2000, 5'd0, 32'd5, 5'd0, 32'd0);
        check("full_hold", {31'b0, bus.full}, 32'd1);
        commit_op(4'd1);
        serve("full_st1", 32'h1004, 32'd0);
        check("full_after_pop", {31'b0, bus.full}, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            commit_op(4'(i));
            serve("full_st", 32'h1000 + 32'(i) * 4, 32'd0);
        end
        commit_op(4'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fifth_ignored", {31'b0, bus.mc_en}, 32'd0);
        end

        // rdy low blocks issue
        bus.rdy = 1'b0;
        issue_op(4'd9, 1'b0, F3_LW, 32'h700, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdy_low_issue", {31'b0, bus.mc_en}, 32'd0);
        end

        // Reset in the middle of an access
        issue_op(4'd2, 1'b0, F3_LW, 32'h800, 5'd0, 32'd0, 5'd0, 32'd0);
        tick();
        check("mid_rst_req", {31'b0, bus.mc_en}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_en", {31'b0, bus.mc_en}, 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("mid_rst_full", {31'b0, bus.full}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_empty", {31'b0, bus.mc_en}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/load_store_queue.md
# load_store_queue

Parametrised in-order load/store queue sitting between dispatch, the ROB and the memory controller in the out-of-order RV32I core. It is the next generation of the fixed 16-entry buffer.
- Generalised in depth, ROB tag width and number of result-broadcast channels.
- Adds same-cycle wakeup of issuing entries.
- Adds non-speculative handling of memory-mapped IO loads.
- Adds a drain mode so a speculative memory access in flight at rollback completes safely and its result is discarded.

## Interface
Parameters:
- DEPTH, 16: queue entries; power of two, ≥2.
- ROB_POS_W, 4: ROB index width; operand tags are ROB_POS_W+1 bits, MSB=1 means pending.
- NUM_CDB, 2: number of broadcast channels snooped.
- IO_BASE, 32'h0003_0000: addresses ≥ IO_BASE are IO.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds except rst and rollback
- rollback  in  1  flush speculative entries
- full  out  1  next-cycle occupancy equals DEPTH; reset 0
- issue  in  1  enqueue one entry
- issue_rob_pos  in  ROB_POS_W  owning ROB slot
- issue_is_store  in  1  1=store, 0=load
- issue_funct3  in  3  RV32I funct3
- issue_rs1_val / issue_rs2_val  in  32  operand values
- issue_rs1_tag / issue_rs2_tag  in  ROB_POS_W+1  operand tags
- issue_imm  in  32  sign-extended offset
- cdb_valid  in  NUM_CDB  per-channel broadcast strobe
- cdb_rob_pos  in  NUM_CDB*ROB_POS_W  packed, channel k at [k*ROB_POS_W +: ROB_POS_W]
- cdb_val  in  NUM_CDB*32  packed values
- commit  in  1  ROB commits the entry owning commit_rob_pos (stores and IO loads)
- commit_rob_pos  in  ROB_POS_W  committed ROB slot
- mc_en, mc_wr  out  1  request / write; reset 0
- mc_addr  out  32; mc_len  out  3 (1/2/4 bytes); mc_w_data  out  32; all reset 0
- mc_done  in  1  one-cycle completion pulse
- mc_r_data  in  32  raw read data, zero-extended by the memory controller
- result  out  1  one-cycle load-result pulse; reset 0
- result_rob_pos  out  ROB_POS_W; result_val  out  32; both reset 0

## Operation
- Circular queue: head, tail, count. count is $clog2(DEPTH)+1 bits, so full and empty are never ambiguous.
- Issue writes at tail. An issue while full is ignored and flagged by an assertion.
- Wakeup: any pending tag equal to {1'b1, cdb_rob_pos[k]} with cdb_valid[k] captures cdb_val[k] and clears the tag. This applies to resident entries and to the entry being issued in the same cycle.
- Commit: sets committed on the busy, uncommitted entry with matching rob_pos. Committed entries always form a prefix starting at head.
- Head eligibility: both tags ready, plus one of:
  - committed; or
  - non-IO load and no rollback this cycle.
- The address for the IO check is rs1_val+imm, modulo 2^32.
- FSM states:
  - IDLE: if the head is eligible, drive mc_en=1 with mc_addr, mc_len and mc_wr. Stores also drive mc_w_data=rs2_val. Go to WAIT.
  - WAIT: on mc_done, drop mc_en and pop the head. For a load, pulse result with the value extended per funct3: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. Go to IDLE.
  - DRAIN: on mc_done, drop mc_en, pop, no result, go to IDLE.
- Rollback:
  - Drop every uncommitted entry: tail = head + number of committed entries; count adjusted to match.
  - A same-cycle issue is discarded.
  - In WAIT with an uncommitted head, go to DRAIN.
  - In WAIT with a committed head, stay in WAIT; the access completes normally.
  - If mc_done coincides with rollback, the access completes in that cycle; a load pulses result only if it was committed.

## Timing
- Issue at edge t: entry valid from t+1. full is a registered look-ahead, so dispatch sampling full=0 may issue.
- Minimum load latency: head eligible in cycle t → mc_en high at t+1 → mc_done at cycle d → result high at d+1, for exactly one cycle.
- Back-to-back: the next request can start from IDLE at d+1, so mc_en is high again at d+2.
- mc_en is held high, with stable address and data, from request until the cycle after mc_done.
- Reset mid-access: all state cleared, FSM returns to IDLE, mc_en=0.

## Structure
- Shared package (core_pkg): funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), the OP_LOAD/OP_STORE opcodes, the tag-valid MSB convention, and a default IO_BASE.
- One sub-module, lsq_wakeup: combinational NUM_CDB-way tag match returning ready-flag and value. It is instantiated twice per entry (rs1, rs2) plus twice for the issue port.

## Test plan
- LW, rs1=0x100, imm=4, tags ready, mc_r_data=0xDEADBEEF one cycle after request → mc_addr=0x104, mc_len=4, result_val=0xDEADBEEF.
- LB with mc_r_data=0x80 → result_val=0xFFFFFF80; LBU with the same data → 0x00000080.
- SW to 0x200 without commit → mc_en stays 0. Commit at cycle 10 → mc_en=1, mc_wr=1 at cycle 11, mc_w_data=rs2_val.
- Load whose address is IO_BASE → no request until committed, then a single request.
- rs1 tag pending on channel 1: CDB delivers the value in the same cycle as issue → entry becomes eligible next cycle with the captured value.
- Non-IO load in WAIT, then rollback → DRAIN; no result on mc_done; committed store behind it is retained and executes afterwards.
- DEPTH=4: four issues → full=1, a fifth issue ignored; one pop → full=0.
